// File: rtl/trigger_ctrl.sv
// -----------------------------------------------------------------------------
// trigger_ctrl
//
// Capture controller for a logic-analyser style trace buffer. After an arm
// request it clears the buffer writer, waits until the buffer has been filled
// once (full pre-trigger history), then watches for a masked compare match.
// The matching sample is tagged, and post_count further samples are stored
// after it before the controller parks in DONE.
//
// Build option:
//   TRIGGER_EDGE_EN  defined   -> trigger on a rising match (hit now, no hit
//                                 on the previous sampled cycle)
//                    undefined -> level trigger (hit alone)
//
// Parameters:
//   DATA_WIDTH  sample width / capture buffer data width
//   ADDR_WIDTH  capture buffer address width (depth 2^ADDR_WIDTH)
//
// Ports:
//   clk           sole clock, posedge
//   reset         asynchronous, active-high reset
//   arm           single-cycle start-capture request (ignored while busy)
//   abort         cancel capture; wins over arm
//   i_data        probed signals, sampled every cycle
//   trig_mask     bits taking part in the trigger compare
//   trig_value    required value of the masked bits
//   post_count    samples stored after the trigger sample, sampled on arm
//   waddr         current write address reported by the buffer writer
//   primed        buffer-has-been-full-once flag from the buffer writer
//   buf_clear     one-cycle pulse resetting the buffer writer
//   write_enable  buffer write strobe, aligned with o_data
//   o_data        i_data delayed by one cycle
//   trig_addr     buffer address holding the trigger sample
//   busy          high in FILL, WAIT_TRIG and POST
//   done          high in DONE
//   dbg_state     current FSM state (IDLE=0 FILL=1 WAIT_TRIG=2 POST=3 DONE=4)
//
// Handshake: arm and abort are level-sampled single-cycle requests on the
// rising clock edge; write_enable qualifies o_data in the same cycle and the
// buffer writer is expected to store o_data at waddr whenever it is high.
// -----------------------------------------------------------------------------
module trigger_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  arm,
   input  logic                  abort,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [DATA_WIDTH-1:0] trig_mask,
   input  logic [DATA_WIDTH-1:0] trig_value,
   input  logic [ADDR_WIDTH-1:0] post_count,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic                  primed,
   output logic                  buf_clear,
   output logic                  write_enable,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [ADDR_WIDTH-1:0] trig_addr,
   output logic                  busy,
   output logic                  done,
   output logic [2:0]            dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_FILL = 3'd1,
      S_WAIT = 3'd2,
      S_POST = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   cnt_q;
   logic                    flag_q;
   logic                    buf_clear_q;
   logic                    we_q;
   logic [DATA_WIDTH-1:0]   o_data_q;
   logic [ADDR_WIDTH-1:0]   trig_addr_q;
   logic                    busy_q;
   logic                    done_q;

   logic                    hit;
   logic                    trig_d;
   logic                    we_d;

   assign hit = (((i_data ^ trig_value) & trig_mask) == '0);

`ifdef TRIGGER_EDGE_EN
   logic prev_hit_q;

   // Tracks the compare result every cycle, independent of FSM state, so the
   // first WAIT_TRIG cycle already knows whether the match was present before.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) prev_hit_q <= 1'b0;
      else       prev_hit_q <= hit;
   end

   assign trig_d = hit & ~prev_hit_q;
`else
   assign trig_d = hit;
`endif

   // A sample is written one cycle after every capturing cycle; abort kills
   // the write that would otherwise follow.
   always_comb begin
      we_d = 1'b0;
      if ((state_q == S_FILL) || (state_q == S_WAIT) || (state_q == S_POST)) begin
         we_d = ~abort;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         flag_q      <= 1'b0;
         buf_clear_q <= 1'b0;
         we_q        <= 1'b0;
         o_data_q    <= '0;
         trig_addr_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         buf_clear_q <= 1'b0;
         flag_q      <= 1'b0;
         o_data_q    <= i_data;
         we_q        <= we_d;

         // The tagged sample is on o_data now; its buffer slot is waddr.
         if (we_q && flag_q && !abort) begin
            trig_addr_q <= waddr;
         end

         if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE, S_DONE: begin
                  if (arm) begin
                     state_q     <= S_FILL;
                     busy_q      <= 1'b1;
                     done_q      <= 1'b0;
                     buf_clear_q <= 1'b1;
                     cnt_q       <= post_count;
                  end
               end
               S_FILL: begin
                  // While the clear pulse is still out, primed may be stale
                  // from the previous capture; wait for the writer to restart.
                  if (primed && !buf_clear_q) begin
                     state_q <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (trig_d) begin
                     flag_q <= 1'b1;
                     // With no post samples requested the trigger sample is the
                     // last write, so skip POST entirely.
                     if (cnt_q == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= S_POST;
                     end
                  end
               end
               S_POST: begin
                  // Each POST cycle yields exactly one post-trigger write.
                  cnt_q <= cnt_q - CNT_ONE;
                  if (cnt_q == CNT_ONE) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign buf_clear    = buf_clear_q;
   assign write_enable = we_q;
   assign o_data       = o_data_q;
   assign trig_addr    = trig_addr_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_trigger_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trigger_ctrl
//
// Directed bench for trigger_ctrl. A small buffer-writer model supplies waddr
// and primed: it restarts on buf_clear, advances on each write and raises
// primed when the address wraps. Inputs change and outputs are observed 1 ns
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_trigger_ctrl;

   localparam int DW = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          arm;
   logic          abort;
   logic [DW-1:0] i_data;
   logic [DW-1:0] trig_mask;
   logic [DW-1:0] trig_value;
   logic [AW-1:0] post_count;
   logic [AW-1:0] waddr;
   logic          primed;
   logic          buf_clear;
   logic          write_enable;
   logic [DW-1:0] o_data;
   logic [AW-1:0] trig_addr;
   logic          busy;
   logic          done;
   logic [2:0]    dbg_state;

   int total = 0;
   int bad = 0;
   int clear_cnt = 0;
   int n_wr;
   logic slot_hit;
   logic ok;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   trigger_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .arm(arm), .abort(abort), .i_data(i_data),
      .trig_mask(trig_mask), .trig_value(trig_value), .post_count(post_count),
      .waddr(waddr), .primed(primed), .buf_clear(buf_clear),
      .write_enable(write_enable), .o_data(o_data), .trig_addr(trig_addr),
      .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   // buffer writer model
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         waddr  <= '0;
         primed <= 1'b0;
      end else if (buf_clear) begin
         waddr  <= '0;
         primed <= 1'b0;
      end else if (write_enable) begin
         waddr <= waddr + 4'd1;
         if (waddr == 4'hF) primed <= 1'b1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (buf_clear) clear_cnt++;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("arm_clear", 32'(buf_clear), 32'd1);
      chk("arm_busy", 32'(busy), 32'd1);
      tick();
   endtask

   task automatic wait_primed(output logic got);
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (primed) begin
            got = 1'b1;
            break;
         end
         tick();
      end
      chk("primed_seen", 32'(got), 32'd1);
   endtask

   task automatic count_writes(input logic [AW-1:0] slot, output int n, output logic hit_slot);
      n = 0;
      hit_slot = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (!write_enable) break;
         n++;
         if (waddr == slot) hit_slot = 1'b1;
         tick();
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset = 1'b1; arm = 1'b0; abort = 1'b0; i_data = 8'h00;
      trig_mask = 8'hFF; trig_value = 8'hA5; post_count = 4'd0;
      #12;
      chk("rst_we", 32'(write_enable), 32'd0);
      chk("rst_clear", 32'(buf_clear), 32'd0);
      chk("rst_odata", 32'(o_data), 32'd0);
      chk("rst_taddr", 32'(trig_addr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // basic capture, post_count=3, A5 five cycles after primed
      i_data = 8'h3C; post_count = 4'd3; clear_cnt = 0;
      do_arm();
      wait_primed(ok);                              // P
      tick();                                       // P+1
      chk("t1_wait", 32'(dbg_state), 32'd2);
      tick(); arm = 1'b1;                           // P+2: arm while busy
      tick(); arm = 1'b0;                           // P+3
      tick(); tick();                               // P+5
      i_data = 8'hA5;
      tick();                                       // P+6
      i_data = 8'h3C;
      chk("t1_we", 32'(write_enable), 32'd1);
      chk("t1_odata", 32'(o_data), 32'hA5);
      chk("t1_post", 32'(dbg_state), 32'd3);
      tick();                                       // P+7
      chk("t1_taddr", 32'(trig_addr), 32'd6);
      count_writes(4'd6, n_wr, slot_hit);
      chk("t1_nwr", 32'(n_wr), 32'd3);
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_clears", 32'(clear_cnt), 32'd1);
      tick(); tick();
      chk("t1_hold", 32'(done), 32'd1);
      chk("t1_we_off", 32'(write_enable), 32'd0);

      // A5 present throughout FILL and into WAIT_TRIG
      i_data = 8'hA5; post_count = 4'd2;
      do_arm();
      wait_primed(ok);                              // P
      tick();                                       // P+1
      chk("t2_wait", 32'(dbg_state), 32'd2);
      tick(); tick();                               // P+3
`ifdef TRIGGER_EDGE_EN
      chk("t2_notrig", 32'(trig_addr), 32'd6);
      chk("t2_stillwait", 32'(dbg_state), 32'd2);
      i_data = 8'h00;
      tick();                                       // P+4
      i_data = 8'hA5;
      tick(); tick();                               // P+6
      chk("t2_taddr", 32'(trig_addr), 32'd5);
`else
      chk("t2_taddr", 32'(trig_addr), 32'd2);
`endif
      count_writes(4'd0, n_wr, slot_hit);
      chk("t2_nwr", 32'(n_wr), 32'd2);
      chk("t2_done", 32'(done), 32'd1);

      // post_count = 0
      i_data = 8'h11; post_count = 4'd0;
      do_arm();
      wait_primed(ok);
      tick();                                       // P+1
      i_data = 8'hA5;
      tick();                                       // P+2
      i_data = 8'h11;
      chk("t3_we", 32'(write_enable), 32'd1);
      chk("t3_odata", 32'(o_data), 32'hA5);
      chk("t3_done", 32'(done), 32'd1);
      tick();                                       // P+3
      chk("t3_we_off", 32'(write_enable), 32'd0);
      chk("t3_taddr", 32'(trig_addr), 32'd2);

      // post_count = 15, trigger slot must survive
      post_count = 4'd15;
      do_arm();
      wait_primed(ok);
      tick(); tick(); tick();                       // P+3
      i_data = 8'hA5;
      tick();                                       // P+4
      i_data = 8'h11;
      chk("t4_odata", 32'(o_data), 32'hA5);
      tick();                                       // P+5
      chk("t4_taddr", 32'(trig_addr), 32'd4);
      count_writes(4'd4, n_wr, slot_hit);
      chk("t4_nwr", 32'(n_wr), 32'd15);
      chk("t4_slot", 32'(slot_hit), 32'd0);
      chk("t4_done", 32'(done), 32'd1);

      // abort during POST, then arm+abort together
      post_count = 4'd5;
      do_arm();
      wait_primed(ok);
      tick();                                       // P+1
      i_data = 8'hA5;
      tick();                                       // P+2
      i_data = 8'h11;
      tick();                                       // P+3
      chk("t5_post", 32'(dbg_state), 32'd3);
      abort = 1'b1;
      tick();                                       // P+4
      abort = 1'b0;
      chk("t5_idle", 32'(dbg_state), 32'd0);
      chk("t5_we", 32'(write_enable), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_taddr", 32'(trig_addr), 32'd2);
      arm = 1'b1; abort = 1'b1;
      tick();
      arm = 1'b0; abort = 1'b0;
      chk("t5_both_idle", 32'(dbg_state), 32'd0);
      chk("t5_both_clear", 32'(buf_clear), 32'd0);

      // async reset mid-POST
      post_count = 4'd10;
      do_arm();
      wait_primed(ok);
      tick();
      i_data = 8'hA5;
      tick();
      i_data = 8'h11;
      tick();                                       // POST
      #3 reset = 1'b1;
      #1;
      chk("t6_we", 32'(write_enable), 32'd0);
      chk("t6_clear", 32'(buf_clear), 32'd0);
      chk("t6_odata", 32'(o_data), 32'd0);
      chk("t6_taddr", 32'(trig_addr), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_done", 32'(done), 32'd0);
      #1 reset = 1'b0;
      tick();
      do_arm();
      abort = 1'b1;
      tick();
      abort = 1'b0;

      // trig_mask = 00
      trig_mask = 8'h00; post_count = 4'd1;
      i_data = 8'($urandom_range(0, 255));
      do_arm();
      wait_primed(ok);
      tick();                                       // P+1
      chk("t7_wait", 32'(dbg_state), 32'd2);
      tick();                                       // P+2
`ifdef TRIGGER_EDGE_EN
      chk("t7_edge_wait", 32'(dbg_state), 32'd2);
      chk("t7_edge_done", 32'(done), 32'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
`else
      chk("t7_post", 32'(dbg_state), 32'd3);
      chk("t7_we", 32'(write_enable), 32'd1);
      tick();                                       // P+3
      chk("t7_taddr", 32'(trig_addr), 32'd2);
      count_writes(4'd2, n_wr, slot_hit);
      chk("t7_nwr", 32'(n_wr), 32'd1);
      chk("t7_done", 32'(done), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
